shift_sequencer: RTL and testbench

Upstream control stage for the 8-bit right shifter/rotator.
- Accepts a shift request (data byte, shift count, rotate mode) over a valid/ready handshake.
- Drives the shifter's load_n, shiftright, asr and parallel load value to load the byte, then shifts exactly the requested number of cycles.
- Keeps a shadow copy of the expected register contents, presented as result, and pulses done on completion.

---
 rtl/shift_sequencer_pkg.sv | 14 +
 rtl/shift_sequencer_shadow.sv | 31 +++
 rtl/shift_sequencer.sv | 101 ++++++++++
 tb/tb_shift_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings and default sizing for the shift sequencer and its shadow register.
package shift_sequencer_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/shift_sequencer_shadow.sv
// Shadow copy of the downstream right shifter/rotator; mirrors its contents bit for bit.
module shift_shadow
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic             rot,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shadow_r;

  // Parallel load wins over shift, matching the shifter's load_n priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= {WIDTH{1'b0}};
    end else if (load) begin
      shadow_r <= load_val;
    end else if (shift_en) begin
      shadow_r <= {(rot ? shadow_r[0] : 1'b0), shadow_r[WIDTH-1:1]};
    end
  end

  assign q = shadow_r;

endmodule

// File: rtl/shift_sequencer.sv
// Control stage for the 8-bit right shifter: accepts a request, loads the shifter,
// steps it the requested number of cycles and reports the shadowed result.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [CNT_W-1:0] req_amount,
  input  logic             req_rot,
  output logic             load_n,
  output logic             shiftright,
  output logic             asr,
  output logic [WIDTH-1:0] load_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] amt_r;
  logic [WIDTH-1:0] data_r;
  logic             rot_r;
  logic             accept_s;

  assign accept_s = (state_r == ST_IDLE) && req_valid;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_s = ST_LOAD;
        else           state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (amt_r == CNT_ZERO) state_s = ST_DONE;
        else                   state_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_ONE) state_s = ST_DONE;
        else                  state_s = ST_SHIFT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, request capture and shift counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      amt_r   <= CNT_ZERO;
      data_r  <= {WIDTH{1'b0}};
      rot_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        data_r <= req_data;
        amt_r  <= req_amount;
        rot_r  <= req_rot;
      end
      if (state_r == ST_LOAD) begin
        cnt_r <= amt_r;
      end else if (state_r == ST_SHIFT) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  shift_shadow #(.WIDTH(WIDTH)) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .load     (state_r == ST_LOAD),
    .shift_en (state_r == ST_SHIFT),
    .rot      (rot_r),
    .load_val (data_r),
    .q        (result)
  );

  // Controls are pure decodes of registered state; asr/load_val come from the capture regs
  assign req_ready  = (state_r == ST_IDLE);
  assign load_n     = (state_r != ST_LOAD);
  assign shiftright = (state_r == ST_SHIFT);
  assign busy       = (state_r == ST_LOAD) || (state_r == ST_SHIFT);
  assign done       = (state_r == ST_DONE);
  assign asr        = rot_r;
  assign load_val   = data_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: phase-based behavioural model checked every cycle plus directed cases.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [3:0] req_amount;
  logic       req_rot;
  logic       load_n;
  logic       shiftright;
  logic       asr;
  logic [7:0] load_val;
  logic       busy;
  logic       done;
  logic [7:0] result;

  shift_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amount (req_amount),
    .req_rot    (req_rot),
    .load_n     (load_n),
    .shiftright (shiftright),
    .asr        (asr),
    .load_val   (load_val),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Final register contents: rotate by n mod 8, or logical shift (zero once n >= 8)
  function automatic logic [7:0] ref_op(input logic [7:0] d, input int n, input logic rot);
    logic [15:0] dd;
    if (rot) begin
      dd = {d, d} >> (n % 8);
      return dd[7:0];
    end else begin
      if (n >= 8) return 8'h00;
      return d >> n;
    end
  endfunction

  // Model: time since the last accept decides the phase (0 load, 1..amt shift, amt+1 done)
  int         cyc   = 0;
  int         acc   = 0;
  int         m_amt = 0;
  int         n_acc = 0;
  int         n_done = 0;
  logic       act    = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_rot  = 1'b0;

  function automatic bit m_idle();
    return !act || ((cyc - acc) > (m_amt + 1));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      act    <= 1'b0;
      m_data <= 8'h00;
      m_rot  <= 1'b0;
      m_amt  <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_idle() && req_valid) begin
        act    <= 1'b1;
        acc    <= cyc + 1;
        m_data <= req_data;
        m_amt  <= int'(req_amount);
        m_rot  <= req_rot;
        n_acc  <= n_acc + 1;
      end
    end
  end

  always @(negedge clk) begin
    int   p;
    logic e_ready, e_load_n, e_sr, e_busy, e_done;
    p = cyc - acc;
    if (m_idle()) begin
      e_ready = 1'b1; e_load_n = 1'b1; e_sr = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else if (p == 0) begin
      e_ready = 1'b0; e_load_n = 1'b0; e_sr = 1'b0; e_busy = 1'b1; e_done = 1'b0;
    end else if (p <= m_amt) begin
      e_ready = 1'b0; e_load_n = 1'b1; e_sr = 1'b1; e_busy = 1'b1; e_done = 1'b0;
    end else begin
      e_ready = 1'b0; e_load_n = 1'b1; e_sr = 1'b0; e_busy = 1'b0; e_done = 1'b1;
    end
    check("req_ready",  {31'd0, req_ready},  {31'd0, e_ready});
    check("load_n",     {31'd0, load_n},     {31'd0, e_load_n});
    check("shiftright", {31'd0, shiftright}, {31'd0, e_sr});
    check("busy",       {31'd0, busy},       {31'd0, e_busy});
    check("done",       {31'd0, done},       {31'd0, e_done});
    check("asr",        {31'd0, asr},        {31'd0, (act ? m_rot : 1'b0)});
    check("load_val",   {24'd0, load_val},   {24'd0, (act ? m_data : 8'h00)});
    if (!act) begin
      check("result_idle", {24'd0, result}, 32'd0);
    end else if (p >= m_amt + 1) begin
      check("result", {24'd0, result}, {24'd0, ref_op(m_data, m_amt, m_rot)});
    end
    if (done === 1'b1) n_done++;
  end

  task automatic wait_accept(input int k);
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (n_acc != k) break;
    end
    check("accept_timeout", {31'd0, (n_acc != k)}, 32'd1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_idle()) break;
    end
    check("idle_timeout", {31'd0, m_idle()}, 32'd1);
  endtask

  task automatic run_req(input logic [7:0] d, input logic [3:0] a, input logic r,
                         input logic [7:0] exp_res, input string name);
    int k, dn;
    @(negedge clk);
    k = n_acc;
    dn = n_done;
    req_valid = 1'b1; req_data = d; req_amount = a; req_rot = r;
    wait_accept(k);
    req_valid = 1'b0;
    wait_idle();
    check({name, "_result"}, {24'd0, result}, {24'd0, exp_res});
    check({name, "_ndone"}, n_done - dn, 32'd1);
  endtask

  initial begin
    int k, a1, a2, dn;
    reset = 1'b1;
    req_valid = 1'b0; req_data = 8'h00; req_amount = 4'd0; req_rot = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("pin_b4_3_lsr",  {24'd0, ref_op(8'hB4, 3, 1'b0)},  32'h16);
    check("pin_81_1_rot",  {24'd0, ref_op(8'h81, 1, 1'b1)},  32'hC0);
    check("pin_5a_8_rot",  {24'd0, ref_op(8'h5A, 8, 1'b1)},  32'h5A);
    check("pin_ff_15_lsr", {24'd0, ref_op(8'hFF, 15, 1'b0)}, 32'h00);

    run_req(8'hB4, 4'd3,  1'b0, 8'h16, "lsr3");
    run_req(8'h81, 4'd1,  1'b1, 8'hC0, "rot1");
    run_req(8'h5A, 4'd8,  1'b1, 8'h5A, "rot8");
    run_req(8'hB4, 4'd0,  1'b0, 8'hB4, "amt0");
    run_req(8'hFF, 4'd15, 1'b0, 8'h00, "lsr15");
    run_req(8'h96, 4'd11, 1'b1, 8'hD2, "rot11");

    // Back-to-back with req_valid held high across both accepts
    @(negedge clk);
    dn = n_done;
    k = n_acc;
    req_valid = 1'b1; req_data = 8'hA5; req_amount = 4'd2; req_rot = 1'b1;
    wait_accept(k);
    a1 = acc;
    req_data = 8'h3C; req_amount = 4'd4; req_rot = 1'b0;
    wait_accept(k + 1);
    a2 = acc;
    req_valid = 1'b0;
    check("b2b_spacing", a2 - a1, 32'd5);
    wait_idle();
    check("b2b_result", {24'd0, result}, 32'h03);
    check("b2b_ndone", n_done - dn, 32'd2);

    // Reset two shifts into an amount-6 request
    @(negedge clk);
    dn = n_done;
    k = n_acc;
    req_valid = 1'b1; req_data = 8'hF0; req_amount = 4'd6; req_rot = 1'b0;
    wait_accept(k);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_shiftright", {31'd0, shiftright}, 32'd0);
    check("rst_ready",      {31'd0, req_ready},  32'd1);
    check("rst_load_n",     {31'd0, load_n},     32'd1);
    check("rst_asr",        {31'd0, asr},        32'd0);
    check("rst_load_val",   {24'd0, load_val},   32'd0);
    check("rst_result",     {24'd0, result},     32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_done", n_done - dn, 32'd0);
    run_req(8'h0F, 4'd2, 1'b1, 8'hC3, "post_rst");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
